// File: rtl/wb_slave_mem_param.sv
// wb_slave_mem_param
//   Wishbone B4 classic-cycle slave backed by an on-chip word memory.
//   Byte-lane writes/reads, configurable widths, depth, base address and
//   wait states. Out-of-range or misaligned accesses terminate with ERR_O.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | no transfer in flight, waiting for CYC_I & STB_I
//   S_WAIT | inserting wait states, counter runs down to 0
//   S_TERM | ACK_O or ERR_O asserted for this single cycle
//
// Ports
//   CLK_I            clock, rising edge
//   RST_I            synchronous active-high reset
//   CYC_I, STB_I     bus cycle / strobe
//   WE_I             1 = write, 0 = read
//   SEL_I            byte-lane enables
//   ADR_I            byte address
//   DAT_I            write data
//   DAT_O            read data, non-zero only during a read ACK
//   ADR_O            byte address of the last terminated transfer
//   ACK_O, ERR_O     one-cycle termination pulses
module wb_slave_mem_param #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                CYC_I,
    input  logic                STB_I,
    input  logic                WE_I,
    input  logic [DATA_W/8-1:0] SEL_I,
    input  logic [ADDR_W-1:0]   ADR_I,
    input  logic [DATA_W-1:0]   DAT_I,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic                ACK_O,
    output logic                ERR_O
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    // Span compared one bit wider than the address so a span equal to the
    // whole address space cannot wrap to zero.
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH * BYTES);
    localparam logic [3:0]      WS_M1 = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TERM
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                req;
    logic                enter_term;

    logic [ADDR_W-1:0]   offs;
    logic [IDX_W-1:0]    idx;
    logic                misaligned;
    logic                out_of_range;
    logic                addr_err;
    logic [DATA_W-1:0]   lane_mask;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign req = CYC_I & STB_I;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_term = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WS_M1;
                    end else begin
                        state_nxt  = S_TERM;
                        enter_term = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Master withdrawing the request abandons it with no side effect.
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt  = S_TERM;
                    enter_term = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_TERM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address decode; offset subtraction wraps, so addresses below the base
    // land far above the span and are rejected as out of range.
    always_comb begin
        offs         = ADR_I - BASE_ADDR;
        idx          = IDX_W'(offs >> LSB);
        misaligned   = (ADR_I & ADDR_W'(BYTES - 1)) != '0;
        out_of_range = {1'b0, offs} >= SPAN;
        addr_err     = misaligned | out_of_range;
        lane_mask    = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_mask[8*i +: 8] = {8{SEL_I[i]}};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            DAT_O <= '0;
            ADR_O <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ACK_O <= enter_term & ~addr_err;
            ERR_O <= enter_term & addr_err;
            DAT_O <= (enter_term && !addr_err && !WE_I) ? (mem[idx] & lane_mask) : '0;
            if (enter_term) begin
                ADR_O <= ADR_I;
            end
        end
    end

    // Memory has no reset; contents survive RST_I.
    always_ff @(posedge CLK_I) begin
        if (!RST_I && enter_term && !addr_err && WE_I) begin
            for (int i = 0; i < BYTES; i++) begin
                if (SEL_I[i]) begin
                    mem[idx][8*i +: 8] <= DAT_I[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem_param.sv
// tb_wb_slave_mem_param
//   Bench for wb_slave_mem_param. Three instances share the bus inputs and
//   are selected by their own CYC_I: u0 (no wait states, base 0),
//   u1 (3 wait states, base 0x1000), u2 (4 wait states, base 0).
//   Stimulus pushes the expected termination into a queue; a monitor on the
//   falling edge pops and compares whenever any instance terminates.
module tb_wb_slave_mem_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc = 3'b000;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic [31:0] dat_o [3];
    logic [31:0] adr_o [3];
    logic [2:0]  ack;
    logic [2:0]  err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int          d;
        bit          err;
        logic [31:0] dat;
        logic [31:0] adr;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    wb_slave_mem_param #(.WAIT_STATES(0)) u0 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[0]), .STB_I(stb), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dat_o[0]),
        .ADR_O(adr_o[0]), .ACK_O(ack[0]), .ERR_O(err[0])
    );

    wb_slave_mem_param #(.BASE_ADDR(32'h1000), .WAIT_STATES(3)) u1 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[1]), .STB_I(stb), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dat_o[1]),
        .ADR_O(adr_o[1]), .ACK_O(ack[1]), .ERR_O(err[1])
    );

    wb_slave_mem_param #(.WAIT_STATES(4)) u2 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc[2]), .STB_I(stb), .WE_I(we),
        .SEL_I(sel), .ADR_I(adr), .DAT_I(dat), .DAT_O(dat_o[2]),
        .ADR_O(adr_o[2]), .ACK_O(ack[2]), .ERR_O(err[2])
    );

    // Monitor: every termination must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d] || err[d]) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_term dut=%0d ack=%0b err=%0b adr_o=%h",
                             d, ack[d], err[d], adr_o[d]);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.d != d || ack[d] != !e.err || err[d] != e.err ||
                        dat_o[d] !== e.dat || adr_o[d] !== e.adr) begin
                        n_err++;
                        $display("FAIL term dut=%0d/%0d ack=%0b err=%0b(exp err=%0b) dat_o=%h exp=%h adr_o=%h exp=%h",
                                 d, e.d, ack[d], err[d], e.err, dat_o[d], e.dat, adr_o[d], e.adr);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int d, input bit e, input logic [31:0] ed,
                            input logic [31:0] a);
        exp_t x;
        x.d   = d;
        x.err = e;
        x.dat = ed;
        x.adr = a;
        sbq.push_back(x);
    endtask

    // Called at posedge+1; counts edges until instance d terminates.
    task automatic wait_term(input int d, output int lat);
        bit done;
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack[d] || err[d]) done = 1'b1;
        end
        if (!done) lat = -1;
    endtask

    task automatic check_lat(input string name, input int lat, input int exp_lat);
        n_checks++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency=%0d exp=%0d", name, lat, exp_lat);
        end
    endtask

    task automatic check_idle(input string name, input int d);
        n_checks++;
        if (ack[d] || err[d]) begin
            n_err++;
            $display("FAIL %s pulse_width ack=%0b err=%0b exp 0", name, ack[d], err[d]);
        end
    endtask

    task automatic xfer(input string name, input int d, input bit w,
                        input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input bit e,
                        input logic [31:0] ed, input int exp_lat);
        int lat;
        push_exp(d, e, ed, a);
        we     = w;
        adr    = a;
        sel    = s;
        dat    = wd;
        cyc[d] = 1'b1;
        stb    = 1'b1;
        wait_term(d, lat);
        check_lat(name, lat, exp_lat);
        cyc[d] = 1'b0;
        stb    = 1'b0;
        @(posedge clk);
        #1;
        check_idle(name, d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int terms;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dat_o[d] !== 32'h0 || adr_o[d] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_state dut=%0d ack=%b err=%b dat_o=%h adr_o=%h exp 0",
                         d, ack[d], err[d], dat_o[d], adr_o[d]);
            end
        end

        // No wait states: basic write/read, empty SEL write.
        xfer("wr_deadbeef", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1);
        xfer("rd_deadbeef", 0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1);
        xfer("wr_sel0", 0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 1);
        xfer("rd_after_sel0", 0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1);

        // Byte lanes.
        xfer("wr_11223344", 0, 1'b1, 32'h0, 4'hF, 32'h11223344, 1'b0, 32'h0, 1);
        xfer("wr_lanes_0101", 0, 1'b1, 32'h0, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0, 1);
        xfer("rd_merged", 0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h11BB33DD, 1);
        xfer("rd_sel_0011", 0, 1'b0, 32'h0, 4'b0011, 32'h0, 1'b0, 32'h000033DD, 1);

        // Three wait states, base 0x1000.
        xfer("wr_base", 1, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0, 32'h0, 4);
        xfer("wr_top", 1, 1'b1, 32'h13FC, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0, 4);

        // Back-to-back reads with STB held.
        push_exp(1, 1'b0, 32'h12345678, 32'h1000);
        we     = 1'b0;
        adr    = 32'h1000;
        sel    = 4'hF;
        cyc[1] = 1'b1;
        stb    = 1'b1;
        wait_term(1, lat);
        check_lat("b2b_first", lat, 4);
        push_exp(1, 1'b0, 32'h12345678, 32'h1000);
        wait_term(1, lat);
        check_lat("b2b_second", lat, 5);
        cyc[1] = 1'b0;
        stb    = 1'b0;
        @(posedge clk);
        #1;
        check_idle("b2b", 1);

        // Error terminations leave memory untouched.
        xfer("err_above", 1, 1'b1, 32'h1400, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 4);
        xfer("err_below", 1, 1'b1, 32'h0FFC, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 4);
        xfer("err_misalign", 1, 1'b1, 32'h1002, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 4);
        xfer("err_rd_above", 1, 1'b0, 32'h1400, 4'hF, 32'h0, 1'b1, 32'h0, 4);
        xfer("rd_base_kept", 1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 32'h12345678, 4);
        xfer("rd_top_kept", 1, 1'b0, 32'h13FC, 4'hF, 32'h0, 1'b0, 32'hA5A5A5A5, 4);

        // Abort with four wait states.
        xfer("wr_55", 2, 1'b1, 32'h20, 4'hF, 32'h00000055, 1'b0, 32'h0, 5);
        we     = 1'b1;
        adr    = 32'h20;
        sel    = 4'hF;
        dat    = 32'hFFFFFFFF;
        cyc[2] = 1'b1;
        stb    = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        cyc[2] = 1'b0;
        stb    = 1'b0;
        terms  = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack[2] || err[2]) terms++;
        end
        n_checks++;
        if (terms != 0) begin
            n_err++;
            $display("FAIL abort_no_term terms=%0d exp 0", terms);
        end
        xfer("rd_after_abort", 2, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h00000055, 5);

        // Reset in the middle of a waited write.
        we     = 1'b1;
        adr    = 32'h20;
        sel    = 4'hF;
        dat    = 32'h00000099;
        cyc[2] = 1'b1;
        stb    = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst    = 1'b1;
        cyc[2] = 1'b0;
        stb    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (ack[2] !== 1'b0 || err[2] !== 1'b0 || dat_o[2] !== 32'h0 || adr_o[2] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_write ack=%b err=%b dat_o=%h adr_o=%h exp 0",
                     ack[2], err[2], dat_o[2], adr_o[2]);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        xfer("rd_after_reset", 2, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h00000055, 5);
        xfer("rd_u0_after_reset", 0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1);

        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain pending=%0d exp 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
